// File: rtl/r5p_bus_arb.sv
// Round-robin arbiter sharing one R5P subordinate port among MN managers.
// Requests pass through combinationally; read data returns one cycle after the transfer.
module r5p_bus_arb #(
   parameter int AW = 22,
   parameter int DW = 32,
   parameter int BW = DW/8,
   parameter int MN = 2
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [MN-1:0]          m_vld,
   input  logic [MN-1:0]          m_wen,
   input  logic [MN-1:0][AW-1:0]  m_adr,
   input  logic [MN-1:0][BW-1:0]  m_ben,
   input  logic [MN-1:0][DW-1:0]  m_wdt,
   output logic [MN-1:0]          m_rdy,
   output logic [MN-1:0]          m_rsp,
   output logic [DW-1:0]          m_rdt,
   output logic                   s_vld,
   output logic                   s_wen,
   output logic [AW-1:0]          s_adr,
   output logic [BW-1:0]          s_ben,
   output logic [DW-1:0]          s_wdt,
   input  logic                   s_rdy,
   input  logic [DW-1:0]          s_rdt
);

   localparam int IW = $clog2(MN);

   // Handshake: a transfer happens on a cycle where vld and rdy are both high;
   // a manager holds its request fields stable until it sees rdy.

   logic [IW-1:0] ptr;
   logic          lock;
   logic [IW-1:0] lidx;
   logic          rsp_v;
   logic [IW-1:0] rsp_idx;

   logic [IW-1:0] gnt;
   logic          gnt_hit;
   logic          xfer;

   always_comb begin : grant_sel
      int idx;
      idx     = 0;
      gnt     = lidx;
      gnt_hit = lock;
      if (!lock) begin
         for (int k = 0; k < MN; k++) begin
            idx = int'(ptr) + k;
            if (idx >= MN) idx = idx - MN;
            if (!gnt_hit && m_vld[IW'(idx)]) begin
               gnt     = IW'(idx);
               gnt_hit = 1'b1;
            end
         end
      end
   end

   always_comb begin
      s_vld = gnt_hit & m_vld[gnt];
      s_wen = 1'b0;
      s_adr = '0;
      s_ben = '0;
      s_wdt = '0;
      m_rdy = '0;
      if (s_vld) begin
         s_wen      = m_wen[gnt];
         s_adr      = m_adr[gnt];
         s_ben      = m_ben[gnt];
         s_wdt      = m_wdt[gnt];
         m_rdy[gnt] = s_rdy;
      end
   end

   assign xfer = s_vld & s_rdy;

   // A stalled grant is held so a new lower-index request cannot preempt it.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr     <= '0;
         lock    <= 1'b0;
         lidx    <= '0;
         rsp_v   <= 1'b0;
         rsp_idx <= '0;
      end else begin
         if (xfer) begin
            if (gnt == IW'(MN-1)) ptr <= '0;
            else                  ptr <= gnt + IW'(1);
            lock <= 1'b0;
         end else if (s_vld) begin
            lock <= 1'b1;
            lidx <= gnt;
         end
         rsp_v <= xfer & ~s_wen;
         if (xfer & ~s_wen) rsp_idx <= gnt;
      end
   end

   always_comb begin
      m_rsp          = '0;
      m_rsp[rsp_idx] = rsp_v;
   end

   assign m_rdt = s_rdt;

endmodule
